// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Two-requester round-robin burst arbiter driving a shared 2:1 mux
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] B,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready,
  output logic             S,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     r_state;
  logic       r_s;
  logic       r_last_gnt;
  logic [7:0] r_beat_cnt;

  logic w_xfer;
  logic w_burst_end;
  logic w_arb_prev;
  logic w_any;
  logic w_pick_b;

  assign Y    = r_s ? B : A;
  assign S    = r_s;
  assign busy = (r_state != ST_IDLE);

  always_comb begin
    y_valid = 1'b0;
    y_last  = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (r_state)
      ST_GNT_A: begin
        y_valid = a_valid;
        y_last  = a_last;
        a_ready = y_ready;
      end
      ST_GNT_B: begin
        y_valid = b_valid;
        y_last  = b_last;
        b_ready = y_ready;
      end
      default: ;
    endcase
    // Reset kills any in-flight handshake in the reset cycle itself.
    if (rst) begin
      y_valid = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  assign w_xfer      = y_valid && y_ready;
  assign w_burst_end = w_xfer && (y_last || (r_beat_cnt == C_LAST_BEAT));

  // At burst end the side just served counts as the last grant.
  assign w_arb_prev = (r_state == ST_IDLE) ? r_last_gnt : r_s;
  assign w_any      = a_valid || b_valid;
  assign w_pick_b   = (a_valid && b_valid) ? ~w_arb_prev : b_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_s        <= 1'b0;
      r_last_gnt <= 1'b1;
      r_beat_cnt <= 8'd0;
    end else if ((r_state == ST_IDLE) || w_burst_end) begin
      if (w_burst_end) begin
        r_last_gnt <= r_s;
      end
      r_beat_cnt <= 8'd0;
      if (w_any) begin
        r_state <= w_pick_b ? ST_GNT_B : ST_GNT_A;
        r_s     <= w_pick_b;
      end else begin
        r_state <= ST_IDLE;
      end
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Brief    : Randomized scoreboard bench for mux2_rr_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int MB    = 4;
  localparam int N_CYC = 3000;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B, Y;
  logic             a_valid, a_last, a_ready;
  logic             b_valid, b_last, b_ready;
  logic             y_valid, y_last, y_ready;
  logic             S, busy;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .A(A), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .B(B), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .Y(Y), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready),
    .S(S), .busy(busy)
  );

  always #5 clk = ~clk;

  // Per-cycle expectation: {Y, S, busy, y_valid, a_ready, b_ready}
  logic [WIDTH+4:0] q_stat[$];
  // Per-transfer expectation: {Y, y_last, S}
  logic [WIDTH+1:0] q_xfer[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: which side owns the channel and beats so far
  int m_owner   = 0;   // 0 none, 1 A, 2 B
  int m_sel     = 0;   // side currently steered by the mux (0 A, 1 B)
  int m_prev    = 2;   // side that finished the most recent burst
  int m_beats   = 0;

  function automatic int choose(input int av, input int bv, input int prev);
    if (av != 0 && bv != 0) return (prev == 1) ? 2 : 1;
    if (bv != 0) return 2;
    if (av != 0) return 1;
    return 0;
  endfunction

  task automatic model_cycle();
    int av, bv, al, bl, yr, ev, ear, ebr, el, nxt;
    logic [WIDTH-1:0] ey;
    av = int'(a_valid); bv = int'(b_valid);
    al = int'(a_last);  bl = int'(b_last); yr = int'(y_ready);
    ey  = (m_sel == 1) ? B : A;
    ev  = 0; ear = 0; ebr = 0; el = 0;
    if (rst == 1'b0 && m_owner == 1) begin ev = av; el = al; ear = yr; end
    if (rst == 1'b0 && m_owner == 2) begin ev = bv; el = bl; ebr = yr; end
    q_stat.push_back({ey, 1'(m_sel), 1'(m_owner != 0), 1'(ev), 1'(ear), 1'(ebr)});
    if (ev != 0 && yr != 0) q_xfer.push_back({ey, 1'(el), 1'(m_sel)});

    if (rst) begin
      m_owner = 0; m_sel = 0; m_prev = 2; m_beats = 0;
    end else if (m_owner == 0 || (ev != 0 && yr != 0 && (el != 0 || m_beats + 1 == MB))) begin
      if (m_owner != 0) m_prev = m_owner;
      nxt = choose(av, bv, m_prev);
      m_beats = 0;
      m_owner = nxt;
      if (nxt != 0) m_sel = nxt - 1;
    end else if (ev != 0 && yr != 0) begin
      m_beats++;
    end
  endtask

  always @(negedge clk) begin
    logic [WIDTH+4:0] es;
    logic [WIDTH+1:0] ex;
    if (q_stat.size() > 0) begin
      es = q_stat.pop_front();
      n_checks++;
      if ({Y, S, busy, y_valid, a_ready, b_ready} === es) n_pass++;
      else $display("FAIL status t=%0t: got Y=%h S=%b busy=%b yv=%b ar=%b br=%b, want Y=%h S=%b busy=%b yv=%b ar=%b br=%b",
                    $time, Y, S, busy, y_valid, a_ready, b_ready,
                    es[WIDTH+4:5], es[4], es[3], es[2], es[1], es[0]);
      if (y_valid === 1'b1 && y_ready === 1'b1) begin
        n_checks++;
        if (q_xfer.size() == 0) begin
          $display("FAIL xfer t=%0t: got unexpected transfer Y=%h, want none", $time, Y);
        end else begin
          ex = q_xfer.pop_front();
          if ({Y, y_last, S} === ex) n_pass++;
          else $display("FAIL xfer t=%0t: got Y=%h last=%b S=%b, want Y=%h last=%b S=%b",
                        $time, Y, y_last, S, ex[WIDTH+1:2], ex[1], ex[0]);
        end
      end
    end
  end

  initial begin
    int contend;
    rst = 1'b1; y_ready = 1'b0;
    A = '0; B = '0;
    a_valid = 1'b0; a_last = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < N_CYC; i++) begin
      #1;
      contend = ((i / 400) % 2 == 0) ? 1 : 0;
      rst     = (i < 2) || ($urandom_range(0, 99) == 0);
      A       = WIDTH'($urandom);
      B       = WIDTH'($urandom);
      a_valid = (i < 2) || (contend != 0) || ($urandom_range(0, 2) != 0);
      b_valid = (i < 2) || (contend != 0) || ($urandom_range(0, 2) != 0);
      a_last  = ($urandom_range(0, 4) == 0);
      b_last  = (contend != 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 6) == 0);
      y_ready = ((i / 250) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0);
      model_cycle();
      @(posedge clk);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_stat.size() == 0 && q_xfer.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d status and %0d transfers outstanding, want 0 and 0",
                  q_stat.size(), q_xfer.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
